// File: rtl/char_buffer_ctrl.sv
// Screen-maintenance controller for the 80x32 character buffer: sequences the
// init engine and arbitrates the single registered buffer write port.
module char_buffer_ctrl #(
  parameter int unsigned MAXCOL        = 80,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_row,
  input  logic [6:0]  cmd_col,
  input  logic        wr_req,
  output logic        wr_ack,
  input  logic [11:0] wr_addr,
  input  logic [6:0]  wr_data,
  output logic        init_enable_n,
  output logic        init_row_only,
  output logic        init_sequential,
  output logic [4:0]  init_row,
  output logic [6:0]  init_col,
  input  logic        init_wr_en,
  input  logic [11:0] init_addr,
  input  logic [6:0]  init_data,
  output logic        buf_we,
  output logic [11:0] buf_addr,
  output logic [6:0]  buf_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned CNT_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_init_enable_n;
  logic               r_init_row_only;
  logic               r_init_sequential;
  logic [ROW_W-1:0]   r_init_row;
  logic [COL_W-1:0]   r_init_col;
  logic               r_buf_we;
  logic [ADDR_W-1:0]  r_buf_addr;
  logic [DATA_W-1:0]  r_buf_data;
  logic               w_accept;
  logic               w_cmd_ok;
  logic               w_timeout;
  logic               w_err_next;
  logic               w_wr_ack;

  assign w_accept  = cmd_valid & r_cmd_ready & (r_state == S_IDLE);
  assign w_cmd_ok  = (cmd_op != 2'd3) && ((cmd_op != 2'd2) || (32'(cmd_col) < MAXCOL));
  assign w_timeout = (r_wait_cnt == CNT_W'(START_TIMEOUT - 1)) & ~init_wr_en;
  // Engine always wins; the writer only gets the port while idle.
  assign w_wr_ack  = wr_req & (r_state == S_IDLE) & ~init_wr_en;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cmd_ok) begin
            w_next_state = S_LAUNCH;
          end else begin
            w_next_state = S_DONE;
            w_err_next   = 1'b1;
          end
        end
      end
      S_LAUNCH:     w_next_state = S_WAIT_START;
      S_WAIT_START: begin
        if (init_wr_en) begin
          w_next_state = S_RUN;
        end else if (w_timeout) begin
          w_next_state = S_DONE;
          w_err_next   = 1'b1;
        end
      end
      S_RUN:        if (!init_wr_en) w_next_state = S_DONE;
      S_DONE:       w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // Cycles spent waiting for the engine's first strobe.
  always_ff @(posedge clk) begin
    if (!resetn || r_state != S_WAIT_START) r_wait_cnt <= '0;
    else                                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  // Status outputs are registered off the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cmd_ready     <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_init_enable_n <= 1'b1;
    end else begin
      r_cmd_ready     <= (w_next_state == S_IDLE);
      r_busy          <= (w_next_state != S_IDLE);
      r_done          <= (w_next_state == S_DONE);
      r_err           <= w_err_next;
      r_init_enable_n <= (w_next_state != S_LAUNCH);
    end
  end

  // Engine configuration: captured on a launching accept, cleared on return to idle.
  always_ff @(posedge clk) begin
    if (!resetn || w_next_state == S_IDLE) begin
      r_init_row_only   <= 1'b0;
      r_init_sequential <= 1'b0;
      r_init_row        <= '0;
      r_init_col        <= '0;
    end else if (w_accept && w_cmd_ok) begin
      r_init_row_only   <= (cmd_op == 2'd2);
      r_init_sequential <= (cmd_op == 2'd1);
      r_init_row        <= cmd_row;
      r_init_col        <= cmd_col;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf_we   <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else if (init_wr_en) begin
      r_buf_we   <= 1'b1;
      r_buf_addr <= init_addr;
      r_buf_data <= init_data;
    end else if (w_wr_ack) begin
      r_buf_we   <= 1'b1;
      r_buf_addr <= wr_addr;
      r_buf_data <= wr_data;
    end else begin
      r_buf_we   <= 1'b0;
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign wr_ack          = w_wr_ack;
  assign init_enable_n   = r_init_enable_n;
  assign init_row_only   = r_init_row_only;
  assign init_sequential = r_init_sequential;
  assign init_row        = r_init_row;
  assign init_col        = r_init_col;
  assign buf_we          = r_buf_we;
  assign buf_addr        = r_buf_addr;
  assign buf_data        = r_buf_data;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Directed bench for char_buffer_ctrl with an init-engine stub and a write-port scoreboard.
module tb_char_buffer_ctrl;

  localparam int MAXCOL = 80;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_row;
  logic [6:0]  cmd_col;
  logic        wr_req;
  logic        wr_ack;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic        init_enable_n;
  logic        init_row_only;
  logic        init_sequential;
  logic [4:0]  init_row;
  logic [6:0]  init_col;
  logic        init_wr_en;
  logic [11:0] init_addr;
  logic [6:0]  init_data;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [6:0]  buf_data;
  logic        busy;
  logic        done;
  logic        err;

  logic        eng_wr = 1'b0;
  logic [11:0] eng_addr = '0;
  logic [6:0]  eng_data = '0;
  logic        stray_wr = 1'b0;
  logic [11:0] stray_addr = '0;
  logic [6:0]  stray_data = '0;
  logic        eng_on = 1'b1;
  logic        eng_abort = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int cur_op = 0, cur_row = 0, cur_col = 0;
  int n_writes = 0, n_pulses = 0, last_we_cyc = 0;
  logic err_bad = 1'b0;
  logic [18:0] sb_q[$];

  assign init_wr_en = eng_wr | stray_wr;
  assign init_addr  = stray_wr ? stray_addr : eng_addr;
  assign init_data  = stray_wr ? stray_data : eng_data;

  char_buffer_ctrl #(.MAXCOL(80), .START_TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_enable_n(init_enable_n), .init_row_only(init_row_only),
    .init_sequential(init_sequential), .init_row(init_row), .init_col(init_col),
    .init_wr_en(init_wr_en), .init_addr(init_addr), .init_data(init_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Init-engine stub: registers the enable pulse, then strobes the expected run.
  always begin
    @(negedge clk);
    if (resetn === 1'b1 && init_enable_n === 1'b0 && eng_on) begin
      int n;
      n = (cur_op == 2) ? (MAXCOL - cur_col) : 2560;
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int i = 0; i < n && !eng_abort; i++) begin
        eng_wr   = 1'b1;
        eng_addr = (cur_op == 2) ? {7'(cur_col + i), 5'(cur_row)} : 12'(i);
        eng_data = (cur_op == 1) ? 7'(i) : 7'd0;
        @(posedge clk);
        #1;
      end
      eng_wr = 1'b0;
    end
  end

  // Scoreboard: each granted write is expected on buf_* one cycle later.
  always @(negedge clk) begin
    logic [18:0] exp;
    if (buf_we === 1'b1) begin
      n_writes++;
      last_we_cyc = cyc;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 19'h7ffff;
      chk("buf_write", {13'd0, buf_addr, buf_data}, {13'd0, exp});
    end
    if (init_wr_en === 1'b1) sb_q.push_back({init_addr, init_data});
    else if (wr_req === 1'b1 && wr_ack === 1'b1) sb_q.push_back({wr_addr, wr_data});
    if (init_enable_n === 1'b0) n_pulses++;
    if (done !== 1'b1 && err !== 1'b0) err_bad = 1'b1;
  end

  task automatic issue(input int op, input int row, input int col, output int t, output logic ack);
    cur_op = op; cur_row = row; cur_col = col;
    cmd_op = 2'(op); cmd_row = 5'(row); cmd_col = 7'(col);
    cmd_valid = 1'b1;
    t = -1;
    ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        t = cyc;
        ack = wr_ack;
        break;
      end
      tick();
    end
    if (t < 0) chk("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic cfg_chk, output int dc, output logic de,
                           output logic hold_bad, output logic ack_bad);
    dc = -1; de = 1'b0; hold_bad = 1'b0; ack_bad = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (wr_ack !== 1'b0) ack_bad = 1'b1;
        if (cfg_chk && (init_row_only !== (cur_op == 2) || init_sequential !== (cur_op == 1) ||
                        init_row !== 5'(cur_row) || init_col !== 7'(cur_col)))
          hold_bad = 1'b1;
      end
      if (done === 1'b1) begin
        dc = cyc;
        de = err;
        tick();
        break;
      end
      tick();
    end
    if (dc < 0) chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cfg"}, {19'd0, init_row_only, init_sequential, init_row, init_col}, 32'd0);
    chk({tag, "_queue"}, 32'(sb_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    int t, dc;
    logic de, hb, ab, acc, bad;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_col = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();

    @(negedge clk);
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_buf_addr", 32'(buf_addr), 32'd0);
    chk("rst_buf_data", 32'(buf_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable_n", 32'(init_enable_n), 32'd1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    resetn = 1'b1;

    // Clear to NUL
    n_writes = 0; n_pulses = 0;
    issue(0, 0, 0, t, acc);
    @(negedge clk);
    chk("op0_enable_low_t1", 32'(init_enable_n), 32'd0);
    chk("op0_busy_t1", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("op0_enable_high_t2", 32'(init_enable_n), 32'd1);
    tick();
    wait_done(3000, 1'b1, dc, de, hb, ab);
    chk("op0_done_latency", 32'(dc), 32'(last_we_cyc + 1));
    chk("op0_err", 32'(de), 32'd0);
    chk("op0_writes", 32'(n_writes), 32'd2560);
    chk("op0_pulses", 32'(n_pulses), 32'd1);
    chk("op0_cfg_hold", 32'(hb), 32'd0);
    check_idle("op0_idle");

    // Clear with sequential pattern
    n_writes = 0; n_pulses = 0;
    issue(1, 3, 9, t, acc);
    wait_done(3000, 1'b1, dc, de, hb, ab);
    chk("op1_err", 32'(de), 32'd0);
    chk("op1_writes", 32'(n_writes), 32'd2560);
    chk("op1_seq_hold", 32'(hb), 32'd0);
    check_idle("op1_idle");

    // Erase row 5 from column 70
    n_writes = 0; n_pulses = 0;
    issue(2, 5, 70, t, acc);
    @(negedge clk);
    chk("op2_cfg_launch", {19'd0, init_row_only, init_sequential, init_row, init_col},
        {19'd0, 1'b1, 1'b0, 5'd5, 7'd70});
    tick();
    wait_done(200, 1'b1, dc, de, hb, ab);
    chk("op2_done_latency", 32'(dc), 32'(last_we_cyc + 1));
    chk("op2_err", 32'(de), 32'd0);
    chk("op2_writes", 32'(n_writes), 32'd10);
    chk("op2_cfg_hold", 32'(hb), 32'd0);
    check_idle("op2_idle");

    // Rejected commands: column out of range, reserved op
    for (int j = 0; j < 2; j++) begin
      n_writes = 0; n_pulses = 0;
      if (j == 0) issue(2, 5, 80, t, acc);
      else        issue(3, 0, 0, t, acc);
      @(negedge clk);
      chk("rej_done", 32'(done), 32'd1);
      chk("rej_err", 32'(err), 32'd1);
      tick();
      @(negedge clk);
      chk("rej_done_clear", {30'd0, done, err}, 32'd0);
      tick();
      repeat (3) tick();
      chk("rej_pulses", 32'(n_pulses), 32'd0);
      chk("rej_writes", 32'(n_writes), 32'd0);
    end

    // Writer contention around an op 0
    wr_addr = 12'h0ab; wr_data = 7'h55; wr_req = 1'b1;
    tick();
    wr_data = 7'h56;
    tick();
    issue(0, 0, 0, t, acc);
    chk("wr_ack_on_accept", 32'(acc), 32'd1);
    wr_addr = 12'h0cd; wr_data = 7'h2a;
    wait_done(3000, 1'b1, dc, de, hb, ab);
    chk("wr_ack_blocked", 32'(ab), 32'd0);
    chk("wr_contend_err", 32'(de), 32'd0);
    @(negedge clk);
    chk("wr_ack_first_idle", 32'(wr_ack), 32'd1);
    tick();
    wr_req = 1'b0;
    repeat (2) tick();
    chk("wr_queue_drained", 32'(sb_q.size()), 32'd0);

    // Stray engine strobe in IDLE beats the writer
    wr_req = 1'b1; wr_addr = 12'h321; wr_data = 7'h33;
    stray_wr = 1'b1; stray_addr = 12'h123; stray_data = 7'h11;
    @(negedge clk);
    chk("stray_wr_ack_suppressed", 32'(wr_ack), 32'd0);
    tick();
    stray_wr = 1'b0;
    @(negedge clk);
    chk("stray_wr_ack_after", 32'(wr_ack), 32'd1);
    tick();
    wr_req = 1'b0;
    repeat (2) tick();
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_queue", 32'(sb_q.size()), 32'd0);

    // Engine never starts: timeout completion
    eng_on = 1'b0;
    issue(0, 0, 0, t, acc);
    bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (done !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("timeout_early_done", 32'(bad), 32'd0);
    @(negedge clk);
    chk("timeout_done", 32'(done), 32'd1);
    chk("timeout_err", 32'(err), 32'd1);
    tick();
    eng_on = 1'b1;
    check_idle("timeout_idle");

    // Reset in the middle of a run
    issue(0, 0, 0, t, acc);
    repeat (20) tick();
    @(negedge clk);
    chk("midrun_busy", 32'(busy), 32'd1);
    tick();
    resetn = 1'b0;
    eng_abort = 1'b1;
    tick();
    @(negedge clk);
    chk("midrun_rst_buf_we", 32'(buf_we), 32'd0);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    chk("midrun_rst_ready", 32'(cmd_ready), 32'd0);
    bad = 1'b0;
    repeat (3) begin
      tick();
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    tick();
    resetn = 1'b1;
    repeat (5) begin
      tick();
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("midrun_no_done", 32'(bad), 32'd0);
    tick();
    sb_q.delete();
    eng_abort = 1'b0;

    chk("err_only_with_done", 32'(err_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
